instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage upstream of Control_Unit. Holds PC and instruction register (IR).
//  On en_fetch_pulse, reads one 32-bit word from instruction memory over a req/ack handshake.
//  Presents the word on Instruction.
//  On en_pc_pulse, advances PC: sequential, or jump-relative using jump/imm_ext from Control_Unit.
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC value after reset
//  NOP_INSTR       32'h0000_0000  IR value on reset and on fetch timeout
//  TIMEOUT_CYCLES  16             REQ cycles before abort (only with IFU_TIMEOUT_EN); >=1
// PORTS
//  clk             in   1   single clock, all state updates on rising edge
//  reset           in   1   synchronous, active-high
//  en_fetch_pulse  in   1   start fetch at current PC (Control_Unit)
//  en_pc_pulse     in   1   update PC (Control_Unit)
//  jump            in   1   select jump target at en_pc_pulse
//  imm_ext         in   32  signed byte offset for jump
//  imem_req        out  1   memory request, level, held until ack
//  imem_addr       out  32  fetch address, stable while imem_req=1
//  imem_ack        in   1   read data valid this cycle
//  imem_rdata      in   32  instruction word, sampled when imem_ack=1 in REQ
//  Instruction     out  32  IR, to Control_Unit
//  instr_pc        out  32  address IR was fetched from
//  pc              out  32  current PC
//  fetch_busy      out  1   1 while state=REQ
//  fetch_done      out  1   one-cycle pulse, IR updated this cycle
//  fetch_err       out  1   fetch timed out (tied 0 without IFU_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values (all outputs registered): pc=RESET_PC, Instruction=NOP_INSTR, instr_pc=RESET_PC,
//   imem_req=0, imem_addr=RESET_PC, fetch_busy=0, fetch_done=0, fetch_err=0, state=IDLE.
//  FSM states: IDLE, REQ.
//  IDLE, en_fetch_pulse=1: go to REQ; imem_req=1; imem_addr=pc; latch instr_pc=pc.
//   Fetch uses the PC value from before any same-cycle en_pc_pulse update.
//  REQ, imem_ack=1: Instruction=imem_rdata; fetch_done=1 for one cycle; imem_req=0; go to IDLE.
//  REQ, imem_ack=0: hold; imem_addr stays stable.
//  Latency: pulse at edge N -> req high from N+1 -> with ack at N+1, IR valid and done at N+2.
//   This 2-cycle minimum is the only latency; each extra ack wait cycle adds 1.
//  en_fetch_pulse during REQ: ignored, no queueing.
//  imem_ack in IDLE: ignored.
//  en_pc_pulse (any state, applied at the edge):
//   pc = jump ? instr_pc + imm_ext : pc + 4.
//   Result bits[1:0] forced to 2'b00.
//   The in-flight fetch keeps its latched imem_addr.
//  Arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
//   Negative imm_ext wraps the same way; no overflow flag.
//  en_pc_pulse and en_fetch_pulse in the same cycle: fetch at old pc, pc updates. Both take effect.
//  Reset in REQ: immediate return to IDLE, all reset values; an ack arriving after reset is ignored.
// CONFIGURATION
//  IFU_TIMEOUT_EN defined:
//   - 5-bit wait counter: cleared on REQ entry, increments each REQ cycle without ack.
//   - When counter reaches TIMEOUT_CYCLES: Instruction=NOP_INSTR, fetch_err=1, fetch_done pulse,
//     imem_req=0, go to IDLE.
//   - fetch_err is sticky; cleared on next accepted en_fetch_pulse or reset.
//   - Ack in the same cycle as the timeout wins: normal completion, no error.
//  IFU_TIMEOUT_EN undefined:
//   - REQ waits indefinitely; fetch_err constant 0; no counter logic.
// TESTING
//  1 reset held 2 cycles -> pc=0, Instruction=0, imem_req=0, fetch_done=0.
//  2 pulse fetch, ack same cycle req rises, rdata=32'h78800003 ->
//    Instruction=32'h78800003 and fetch_done 2 cycles after pulse; instr_pc=0.
//  3 fetch with ack delayed 3 cycles, extra en_fetch_pulse mid-wait -> imem_addr stable,
//    exactly one fetch_done.
//  4 pc=8 instr_pc=8, jump=1, imm_ext=-8, en_pc_pulse -> pc=0.
//    pc=32'hFFFFFFFC, jump=0 -> pc=0.
//    imm_ext=6 from instr_pc=0 -> pc=4 (low bits cleared).
//  5 same-cycle en_fetch_pulse + en_pc_pulse at pc=4 -> imem_addr=4, pc=8.
//    reset asserted in REQ, late ack -> Instruction stays 0, no fetch_done.
//  6 (IFU_TIMEOUT_EN, TIMEOUT_CYCLES=4) no ack -> after 4 REQ cycles:
//    fetch_err=1, Instruction=0, fetch_done pulse; next fetch clears fetch_err.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/ack bus between fetch unit and imem
//
// Purpose : groups the instruction-memory handshake into one bundle.
// Signals : imem_req   (master->slave) level request, held until imem_ack
//           imem_addr  (master->slave) fetch address, stable while imem_req=1
//           imem_ack   (slave->master) imem_rdata valid this cycle
//           imem_rdata (slave->master) instruction word
`timescale 1ns/1ps

interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, instruction register and imem req/ack fetch FSM
//
// Purpose : holds PC and IR; on en_fetch_pulse reads one word from instruction
//           memory over a req/ack handshake; on en_pc_pulse advances PC either
//           sequentially (pc+4) or jump-relative (instr_pc+imm_ext).
// Optional: IFU_TIMEOUT_EN - abort a fetch after TIMEOUT_CYCLES REQ cycles
//           without ack, load NOP_INSTR and raise sticky fetch_err.
// Ports   : clk, reset        single clock, synchronous active-high reset
//           en_fetch_pulse    start a fetch at the current PC (ignored while busy)
//           en_pc_pulse       update PC this edge
//           jump, imm_ext     select/offset for jump-relative PC update
//           imem              instruction memory bus (master side)
//           Instruction       instruction register
//           instr_pc          address the IR was fetched from
//           pc                current program counter
//           fetch_busy        high while a fetch is outstanding
//           fetch_done        one-cycle pulse when IR has been updated
//           fetch_err         sticky timeout flag (constant 0 without IFU_TIMEOUT_EN)
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_fetch_pulse,
    input  logic                      en_pc_pulse,
    input  logic                      jump,
    input  logic [31:0]               imm_ext,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               Instruction,
    output logic [31:0]               instr_pc,
    output logic [31:0]               pc,
    output logic                      fetch_busy,
    output logic                      fetch_done,
    output logic                      fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // The wait counter is 5 bits wide, so the abort threshold must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout_cfg
        $error("instr_fetch_unit: TIMEOUT_CYCLES must be in 1..31");
    end

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_instr_pc;
    logic [31:0] r_imem_addr;
    logic        r_imem_req;
    logic        r_fetch_done;

    logic        w_accept;      // fetch request taken in IDLE
    logic        w_complete;    // ack taken in REQ
    logic        w_timeout;     // REQ aborted by wait counter
    logic [31:0] w_pc_target;

`ifdef IFU_TIMEOUT_EN
    localparam logic [4:0] LP_WAIT_LAST = 5'(TIMEOUT_CYCLES - 1);

    logic [4:0]  r_wait_cnt;
    logic        r_fetch_err;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                // imem_ack is deliberately ignored here: a stray or late ack
                // (e.g. one crossing a reset) must not touch the IR.
                if (en_fetch_pulse) begin
                    w_accept     = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                // Ack has priority over the timeout when both land together.
                if (imem.imem_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
`ifdef IFU_TIMEOUT_EN
                else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Jump target is relative to the fetched instruction's address, not the
    // (possibly already advanced) PC. The two low bits are dropped so the PC
    // stays word aligned; arithmetic wraps modulo 2^32.
    assign w_pc_target = jump ? (r_instr_pc + imm_ext) : (r_pc + 32'd4);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_ir         <= NOP_INSTR;
            r_instr_pc   <= RESET_PC;
            r_imem_addr  <= RESET_PC;
            r_imem_req   <= 1'b0;
            r_fetch_done <= 1'b0;
        end else begin
            r_fetch_done <= 1'b0;

            // The fetch below samples r_pc, i.e. the value from before this
            // edge's PC update, so a same-cycle fetch+pc pulse fetches old pc.
            if (en_pc_pulse) begin
                r_pc <= w_pc_target & ~32'd3;
            end

            if (w_accept) begin
                r_imem_req  <= 1'b1;
                r_imem_addr <= r_pc;
                r_instr_pc  <= r_pc;
            end

            if (w_complete) begin
                r_ir         <= imem.imem_rdata;
                r_fetch_done <= 1'b1;
                r_imem_req   <= 1'b0;
            end

            if (w_timeout) begin
                r_ir         <= NOP_INSTR;
                r_fetch_done <= 1'b1;
                r_imem_req   <= 1'b0;
            end
        end
    end

`ifdef IFU_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Fetch timeout: counts REQ cycles without ack; error flag is sticky
    // until the next accepted fetch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= 5'd0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait_cnt  <= 5'd0;
                r_fetch_err <= 1'b0;
            end else if (r_state == REQ && !imem.imem_ack && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 5'd1;
            end

            if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    assign fetch_err = r_fetch_err;
`else
    assign fetch_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------
    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_imem_addr;
    assign Instruction    = r_ir;
    assign instr_pc       = r_instr_pc;
    assign pc             = r_pc;
    assign fetch_busy     = r_imem_req;
    assign fetch_done     = r_fetch_done;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_fetch_pulse;
    logic        en_pc_pulse;
    logic        jump;
    logic [31:0] imm_ext;
    logic [31:0] Instruction;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit_if u_if ();

    instr_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .NOP_INSTR      (32'h0000_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en_fetch_pulse (en_fetch_pulse),
        .en_pc_pulse    (en_pc_pulse),
        .jump           (jump),
        .imm_ext        (imm_ext),
        .imem           (u_if.master),
        .Instruction    (Instruction),
        .instr_pc       (instr_pc),
        .pc             (pc),
        .fetch_busy     (fetch_busy),
        .fetch_done     (fetch_done),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fetch;
        logic        pcp;
        logic        jmp;
        logic [31:0] imm;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
        logic [31:0] e_ipc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_done;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic p, input logic j, input logic [31:0] imm,
                         input logic a, input logic [31:0] rd);
        en_fetch_pulse    = f;
        en_pc_pulse       = p;
        jump              = j;
        imm_ext           = imm;
        u_if.imem_ack     = a;
        u_if.imem_rdata   = rd;
    endtask

    // Apply inputs mid-cycle, let one rising edge pass, sample 1ns later.
    task automatic step(input logic f, input logic p, input logic j, input logic [31:0] imm,
                        input logic a, input logic [31:0] rd);
        @(negedge clk);
        drive(f, p, j, imm, a, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ndone;

        //              f  p  j  imm           ack rdata         e_pc          e_ir          e_ipc         req addr          done
        vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b1,32'h0,        1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h78800003, 32'h0,        32'h78800003, 32'h0,        1'b0,32'h0,        1'b1};
        vecs[2]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h4,        32'h78800003, 32'h0,        1'b0,32'h0,        1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h8,        32'h78800003, 32'h0,        1'b0,32'h0,        1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8,        32'h78800003, 32'h8,        1'b1,32'h8,        1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hAAAA0001, 32'h8,        32'hAAAA0001, 32'h8,        1'b0,32'h8,        1'b1};
        vecs[6]  = '{1'b0,1'b1,1'b1,32'hFFFFFFF8, 1'b0,32'h0,        32'h0,        32'hAAAA0001, 32'h8,        1'b0,32'h8,        1'b0};
        vecs[7]  = '{1'b0,1'b1,1'b1,32'h6,        1'b0,32'h0,        32'hC,        32'hAAAA0001, 32'h8,        1'b0,32'h8,        1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h10,       32'hAAAA0001, 32'hC,        1'b1,32'hC,        1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h10,       32'hAAAA0001, 32'hC,        1'b1,32'hC,        1'b0};
        vecs[10] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h14,       32'hAAAA0001, 32'hC,        1'b1,32'hC,        1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h12345678, 32'h14,       32'h12345678, 32'hC,        1'b0,32'hC,        1'b1};
        vecs[12] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hDEADBEEF, 32'h14,       32'h12345678, 32'hC,        1'b0,32'hC,        1'b0};
        vecs[13] = '{1'b0,1'b1,1'b1,32'hFFFFFFF4, 1'b0,32'h0,        32'h0,        32'h12345678, 32'hC,        1'b0,32'hC,        1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h12345678, 32'h0,        1'b1,32'h0,        1'b0};
        vecs[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h00000013, 32'h0,        32'h00000013, 32'h0,        1'b0,32'h0,        1'b1};
        vecs[16] = '{1'b0,1'b1,1'b1,32'h6,        1'b0,32'h0,        32'h4,        32'h00000013, 32'h0,        1'b0,32'h0,        1'b0};
        vecs[17] = '{1'b0,1'b1,1'b1,32'hFFFFFFFC, 1'b0,32'h0,        32'hFFFFFFFC, 32'h00000013, 32'h0,        1'b0,32'h0,        1'b0};
        vecs[18] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h00000013, 32'h0,        1'b0,32'h0,        1'b0};
        vecs[19] = '{1'b0,1'b1,1'b1,32'h7FFFFFFF, 1'b0,32'h0,        32'h7FFFFFFC, 32'h00000013, 32'h0,        1'b0,32'h0,        1'b0};
        vecs[20] = '{1'b0,1'b1,1'b1,32'h3,        1'b0,32'h0,        32'h0,        32'h00000013, 32'h0,        1'b0,32'h0,        1'b0};

        // Reset held two cycles.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",       pc,            32'h0);
        chk("rst_ir",       Instruction,   32'h0);
        chk("rst_instr_pc", instr_pc,      32'h0);
        chk("rst_req",      {31'h0, u_if.imem_req}, 32'h0);
        chk("rst_addr",     u_if.imem_addr, 32'h0);
        chk("rst_done",     {31'h0, fetch_done}, 32'h0);
        chk("rst_busy",     {31'h0, fetch_busy}, 32'h0);
        chk("rst_err",      {31'h0, fetch_err},  32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors: one clock edge per record.
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].fetch, vecs[i].pcp, vecs[i].jmp, vecs[i].imm, vecs[i].ack, vecs[i].rdata);
            chk($sformatf("v%0d_pc", i),    pc,             vecs[i].e_pc);
            chk($sformatf("v%0d_ir", i),    Instruction,    vecs[i].e_ir);
            chk($sformatf("v%0d_ipc", i),   instr_pc,       vecs[i].e_ipc);
            chk($sformatf("v%0d_req", i),   {31'h0, u_if.imem_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_busy", i),  {31'h0, fetch_busy},    {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  u_if.imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_done", i),  {31'h0, fetch_done},    {31'h0, vecs[i].e_done});
            chk($sformatf("v%0d_err", i),   {31'h0, fetch_err},     32'h0);
        end

`ifdef IFU_TIMEOUT_EN
        // Timeout after 4 REQ cycles without ack (state: pc=0, IR=0x13).
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("to_req0", {31'h0, u_if.imem_req}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk($sformatf("to_wait%0d_req", k), {31'h0, u_if.imem_req}, 32'h1);
            chk($sformatf("to_wait%0d_err", k), {31'h0, fetch_err},     32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("to_req",  {31'h0, u_if.imem_req}, 32'h0);
        chk("to_err",  {31'h0, fetch_err},     32'h1);
        chk("to_done", {31'h0, fetch_done},    32'h1);
        chk("to_ir",   Instruction,            32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("to_sticky_err", {31'h0, fetch_err},  32'h1);
        chk("to_done_pulse", {31'h0, fetch_done}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("to_err_clear", {31'h0, fetch_err}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0BADF00D);
        chk("to_refetch_ir", Instruction, 32'h0BADF00D);
        // Ack landing on the timeout cycle wins.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55AA55AA);
        chk("ackwin_ir",   Instruction,         32'h55AA55AA);
        chk("ackwin_err",  {31'h0, fetch_err},  32'h0);
        chk("ackwin_done", {31'h0, fetch_done}, 32'h1);
`else
        // No timeout: a long wait keeps the request up and never errors.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("long_req",  {31'h0, u_if.imem_req}, 32'h1);
        chk("long_err",  {31'h0, fetch_err},     32'h0);
        chk("long_done", {31'h0, fetch_done},    32'h0);
        chk("long_ir",   Instruction,            32'h00000013);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55AA55AA);
        chk("long_ack_ir",   Instruction,         32'h55AA55AA);
        chk("long_ack_done", {31'h0, fetch_done}, 32'h1);
`endif
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Same-cycle fetch + pc pulse at pc=4: fetch uses 4, pc becomes 8.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("pre_pc4", pc, 32'h4);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("same_addr", u_if.imem_addr, 32'h4);
        chk("same_pc",   pc,             32'h8);
        chk("same_ipc",  instr_pc,       32'h4);

        // Ack delayed 3 cycles with an extra fetch pulse mid-wait.
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            step((k == 1), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk($sformatf("dly%0d_addr", k), u_if.imem_addr, 32'h4);
            chk($sformatf("dly%0d_req", k),  {31'h0, u_if.imem_req}, 32'h1);
            if (fetch_done) ndone++;
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE0004);
        chk("dly_done_edge", {31'h0, fetch_done}, 32'h1);
        chk("dly_ir",        Instruction,         32'hC0DE0004);
        if (fetch_done) ndone++;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            if (fetch_done) ndone++;
        end
        chk("dly_done_count", ndone, 32'd1);
        chk("dly_req_idle",   {31'h0, u_if.imem_req}, 32'h0);

        // Reset while in REQ, then a late ack must be ignored.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rreq_req", {31'h0, u_if.imem_req}, 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rreq_req_low", {31'h0, u_if.imem_req}, 32'h0);
        chk("rreq_ir",      Instruction,            32'h0);
        chk("rreq_pc",      pc,                     32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D);
            chk($sformatf("late_ack%0d_done", k), {31'h0, fetch_done}, 32'h0);
            chk($sformatf("late_ack%0d_ir", k),   Instruction,         32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
